// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit x^4+x^3+1 LFSR generator and its checker.
package lfsr_pkg;

    localparam int LFSR_W = 4;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // One step of the maximal-length sequence; 0000 maps to itself (lockup).
    function automatic logic [LFSR_W-1:0] lfsr4_next(input logic [LFSR_W-1:0] q);
        return {q[2:0], q[3] ^ q[2]};
    endfunction

    function automatic logic [2:0] popcount4(input logic [LFSR_W-1:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/lfsr_4bit_checker.sv
// Self-synchronising checker for the 4-bit LFSR stream: locks onto the
// sequence, then flags mismatching words and keeps saturating error counts.
module lfsr_4bit_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        data_in,
    input  logic              valid_in,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_words,
    output logic [ERR_W-1:0]  err_bits
);

    localparam logic [3:0]       LOCK_CNT_C = 4'(LOCK_CNT);
    localparam logic [3:0]       LOSS_CNT_C = 4'(LOSS_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

    chk_state_t        r_state;
    logic              r_first;
    logic [3:0]        r_prev;
    logic [3:0]        r_expected;
    logic [3:0]        r_match_cnt;
    logic [3:0]        r_bad_cnt;
    logic              r_locked;
    logic              r_err_pulse;
    logic [ERR_W-1:0]  r_err_words;
    logic [ERR_W-1:0]  r_err_bits;

    chk_state_t        w_state_n;
    logic              w_first_n;
    logic [3:0]        w_prev_n;
    logic [3:0]        w_expected_n;
    logic [3:0]        w_match_n;
    logic [3:0]        w_bad_n;
    logic              w_err;
    logic [3:0]        w_diff;
    logic [2:0]        w_pop;
    logic [ERR_W:0]    w_words_sum;
    logic [ERR_W:0]    w_bits_sum;
    logic [ERR_W-1:0]  w_err_words_n;
    logic [ERR_W-1:0]  w_err_bits_n;

    // Sync/compare FSM: SEARCH learns the phase from data_in, LOCKED free-runs expected.
    always_comb begin
        w_state_n    = r_state;
        w_first_n    = r_first;
        w_prev_n     = r_prev;
        w_expected_n = r_expected;
        w_match_n    = r_match_cnt;
        w_bad_n      = r_bad_cnt;
        w_err        = 1'b0;
        w_diff       = data_in ^ r_expected;
        w_pop        = popcount4(w_diff);
        if (valid_in) begin
            case (r_state)
                SEARCH: begin
                    w_prev_n = data_in;
                    if (r_first) begin
                        w_first_n = 1'b0;
                        w_match_n = 4'd0;
                    end else if ((data_in == lfsr4_next(r_prev)) && (data_in != 4'b0000)) begin
                        if ((r_match_cnt + 4'd1) == LOCK_CNT_C) begin
                            w_state_n    = LOCKED;
                            w_expected_n = lfsr4_next(data_in);
                            w_match_n    = 4'd0;
                            w_bad_n      = 4'd0;
                        end else begin
                            w_match_n = r_match_cnt + 4'd1;
                        end
                    end else begin
                        w_match_n = 4'd0;
                    end
                end
                LOCKED: begin
                    w_expected_n = lfsr4_next(r_expected);
                    if (w_diff != 4'b0000) begin
                        w_err = 1'b1;
                        if ((r_bad_cnt + 4'd1) == LOSS_CNT_C) begin
                            w_state_n = SEARCH;
                            w_first_n = 1'b1;
                            w_match_n = 4'd0;
                            w_bad_n   = 4'd0;
                        end else begin
                            w_bad_n = r_bad_cnt + 4'd1;
                        end
                    end else begin
                        w_bad_n = 4'd0;
                    end
                end
                default: begin
                    w_state_n = SEARCH;
                    w_first_n = 1'b1;
                    w_match_n = 4'd0;
                    w_bad_n   = 4'd0;
                end
            endcase
        end else begin
            w_err = 1'b0;
        end
    end

    // Saturating error counters; a clear in the same cycle as an error wins.
    always_comb begin
        w_words_sum = {1'b0, r_err_words} + {{ERR_W{1'b0}}, 1'b1};
        w_bits_sum  = {1'b0, r_err_bits} + {{(ERR_W-2){1'b0}}, w_pop};
        if (clr_cnt) begin
            w_err_words_n = {ERR_W{1'b0}};
            w_err_bits_n  = {ERR_W{1'b0}};
        end else if (w_err) begin
            w_err_words_n = w_words_sum[ERR_W] ? ERR_MAX : w_words_sum[ERR_W-1:0];
            w_err_bits_n  = w_bits_sum[ERR_W]  ? ERR_MAX : w_bits_sum[ERR_W-1:0];
        end else begin
            w_err_words_n = r_err_words;
            w_err_bits_n  = r_err_bits;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SEARCH;
            r_first     <= 1'b1;
            r_prev      <= 4'b0000;
            r_expected  <= 4'b0000;
            r_match_cnt <= 4'd0;
            r_bad_cnt   <= 4'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_words <= {ERR_W{1'b0}};
            r_err_bits  <= {ERR_W{1'b0}};
        end else begin
            r_state     <= w_state_n;
            r_first     <= w_first_n;
            r_prev      <= w_prev_n;
            r_expected  <= w_expected_n;
            r_match_cnt <= w_match_n;
            r_bad_cnt   <= w_bad_n;
            r_locked    <= (w_state_n == LOCKED);
            r_err_pulse <= w_err;
            r_err_words <= w_err_words_n;
            r_err_bits  <= w_err_bits_n;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_words = r_err_words;
    assign err_bits  = r_err_bits;

endmodule
